// File: rtl/route_sequencer.sv
// Route step sequencer for the train controller.
// Walks a 16-step route, drives the sensor synchronizer's Selector/Enable,
// qualifies the synchronizer's Y through a dwell filter before advancing,
// and trips a sticky watchdog fault when a step never completes.
module route_sequencer #(
  parameter int unsigned DWELL_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear_fault,
  input  logic       sync_y,
  output logic [4:0] selector,
  output logic       sync_en,
  output logic       run,
  output logic       dir,
  output logic       busy,
  output logic       lap_done,
  output logic       fault
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_DWELL   = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  // Last timeout count before the watchdog trips.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // Dwell count that, with one more qualifying cycle, completes the step.
  localparam logic [7:0]       DWELL_LAST   = 8'(DWELL_CYCLES - 1);

  logic [2:0]       state, state_n;
  logic [3:0]       step, step_n;
  logic [7:0]       dwell_cnt, dwell_n;
  logic [CNT_W-1:0] timeout_cnt, timeout_n;
  logic             lap_n;
  logic             do_advance;
  logic             active;
  logic             run_n, busy_n, fault_n;

  logic             sync_en_q, run_q, dir_q, busy_q, lap_q, fault_q;

  // Current state drives the synchronizer Enable toggling.
  assign active = (state == S_SETTLE) || (state == S_WAIT) || (state == S_DWELL);

  // Next-state, step and counter logic; stop outranks sync_y, which outranks the timeout.
  always_comb begin
    state_n    = state;
    step_n     = step;
    dwell_n    = dwell_cnt;
    timeout_n  = timeout_cnt;
    lap_n      = 1'b0;
    do_advance = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_n = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (stop) begin
          state_n   = S_IDLE;
          dwell_n   = '0;
          timeout_n = '0;
        end else begin
          state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        if (stop) begin
          state_n   = S_IDLE;
          dwell_n   = '0;
          timeout_n = '0;
        end else if (sync_y) begin
          if (DWELL_CYCLES == 1) begin
            do_advance = 1'b1;
          end else begin
            state_n = S_DWELL;
            dwell_n = 8'd1;
          end
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          state_n = S_FAULT;
        end else begin
          timeout_n = timeout_cnt + 1'b1;
        end
      end

      S_DWELL: begin
        if (stop) begin
          state_n   = S_IDLE;
          dwell_n   = '0;
          timeout_n = '0;
        end else if (sync_y) begin
          if (dwell_cnt == DWELL_LAST) begin
            do_advance = 1'b1;
          end else begin
            dwell_n = dwell_cnt + 8'd1;
          end
        end else begin
          // Timeout count is deliberately kept so a bouncing sensor cannot defeat the watchdog.
          state_n = S_WAIT;
          dwell_n = '0;
        end
      end

      S_ADVANCE: begin
        dwell_n   = '0;
        timeout_n = '0;
        state_n   = stop ? S_IDLE : S_SETTLE;
      end

      S_FAULT: begin
        if (clear_fault) begin
          state_n   = S_IDLE;
          timeout_n = '0;
        end
      end

      default: begin
        state_n   = S_IDLE;
        dwell_n   = '0;
        timeout_n = '0;
      end
    endcase

    // The step increments on entry to ADVANCE so a stop during ADVANCE keeps it.
    if (do_advance) begin
      state_n   = S_ADVANCE;
      step_n    = step + 4'd1;
      lap_n     = (step == 4'hF);
      dwell_n   = '0;
      timeout_n = '0;
    end
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    run_n   = (state_n == S_SETTLE) || (state_n == S_WAIT) || (state_n == S_DWELL);
    busy_n  = (state_n != S_IDLE) && (state_n != S_FAULT);
    fault_n = (state_n == S_FAULT);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      step        <= '0;
      dwell_cnt   <= '0;
      timeout_cnt <= '0;
      sync_en_q   <= 1'b0;
      run_q       <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      lap_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_n;
      step        <= step_n;
      dwell_cnt   <= dwell_n;
      timeout_cnt <= timeout_n;
      sync_en_q   <= active ? ~sync_en_q : sync_en_q;
      run_q       <= run_n;
      dir_q       <= step_n[3];
      busy_q      <= busy_n;
      lap_q       <= lap_n;
      fault_q     <= fault_n;
    end
  end

  assign selector = {1'b0, step};
  assign sync_en  = sync_en_q;
  assign run      = run_q;
  assign dir      = dir_q;
  assign busy     = busy_q;
  assign lap_done = lap_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_route_sequencer.sv
// Self-checking bench for route_sequencer: behavioural route model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_route_sequencer;

  localparam int DW = 4;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear_fault = 1'b0;
  logic       sync_y = 1'b0;
  logic [4:0] selector;
  logic       sync_en, run, dir, busy, lap_done, fault;

  route_sequencer #(
    .DWELL_CYCLES(DW),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .clear_fault(clear_fault),
    .sync_y(sync_y),
    .selector(selector),
    .sync_en(sync_en),
    .run(run),
    .dir(dir),
    .busy(busy),
    .lap_done(lap_done),
    .fault(fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_laps = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Route model: counts consecutive Y highs and zero-Y waiting cycles directly.
  typedef enum int {M_IDLE, M_SETTLE, M_WAIT, M_DWELL, M_ADV, M_FAULT} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_sel = 0, m_highs = 0, m_waited = 0;
  bit    m_en = 0, m_lap = 0;

  always @(posedge clk) begin
    m_lap = 0;
    if (reset) begin
      m_mode = M_IDLE; m_sel = 0; m_highs = 0; m_waited = 0; m_en = 0;
    end else begin
      if (m_mode inside {M_SETTLE, M_WAIT, M_DWELL}) m_en = !m_en;
      if (stop && (m_mode inside {M_SETTLE, M_WAIT, M_DWELL, M_ADV})) begin
        m_mode = M_IDLE; m_highs = 0; m_waited = 0;
      end else begin
        case (m_mode)
          M_IDLE:   if (start && !stop) m_mode = M_SETTLE;
          M_SETTLE: m_mode = M_WAIT;
          M_WAIT, M_DWELL: begin
            if (sync_y) begin
              m_highs = m_highs + 1;
              if (m_highs >= DW) begin
                m_mode = M_ADV;
                m_sel = (m_sel + 1) % 16;
                m_lap = (m_sel == 0);
                m_highs = 0; m_waited = 0;
              end else begin
                m_mode = M_DWELL;
              end
            end else if (m_mode == M_DWELL) begin
              m_highs = 0; m_mode = M_WAIT;
            end else begin
              m_waited = m_waited + 1;
              if (m_waited >= TO) m_mode = M_FAULT;
            end
          end
          M_ADV:   m_mode = M_SETTLE;
          M_FAULT: if (clear_fault) begin m_mode = M_IDLE; m_waited = 0; end
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #2;
    check("selector", int'(selector), m_sel);
    check("sync_en",  int'(sync_en),  int'(m_en));
    check("run",      int'(run),      int'(m_mode inside {M_SETTLE, M_WAIT, M_DWELL}));
    check("dir",      int'(dir),      int'(m_sel >= 8));
    check("busy",     int'(busy),     int'(!(m_mode inside {M_IDLE, M_FAULT})));
    check("lap_done", int'(lap_done), int'(m_lap));
    check("fault",    int'(fault),    int'(m_mode == M_FAULT));
    if (lap_done === 1'b1) dut_laps++;
  end

  task automatic wait_for(input string name, input int sel, input mode_t mode);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (m_sel == sel) && (m_mode == mode);
    end
    check({"reach_", name}, int'(ok), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    bit pat[9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};

    repeat (3) @(negedge clk);
    check("rst_selector", int'(selector), 0);
    check("rst_run",      int'(run),      0);
    check("rst_busy",     int'(busy),     0);
    check("rst_fault",    int'(fault),    0);
    check("rst_sync_en",  int'(sync_en),  0);

    // start and stop together hold IDLE
    reset = 0; start = 1; stop = 1;
    repeat (3) @(negedge clk);
    check("startstop_busy", int'(busy), 0);
    check("startstop_run",  int'(run),  0);

    // free-running route with Y held high: 6 cycles per step
    stop = 0; sync_y = 1;
    @(negedge clk);
    check("settle_run", int'(run), 1);
    repeat (5) @(negedge clk);
    check("adv1_selector", int'(selector), 1);
    check("adv1_run",      int'(run),      0);
    @(negedge clk);
    check("settle1_run", int'(run), 1);

    wait_for("wrap", 0, M_ADV);
    check("wrap_lap_done", int'(lap_done), 1);
    check("wrap_dir",      int'(dir),      0);
    @(negedge clk);
    check("wrap_lap_clear", int'(lap_done), 0);

    // dwell interrupted once at step 3
    wait_for("step3", 3, M_ADV);
    foreach (pat[i]) begin
      sync_y = pat[i];
      @(negedge clk);
    end
    check("bounce_selector", int'(selector), 4);
    check("bounce_run",      int'(run),      0);
    check("lap_count",       dut_laps,       1);

    // watchdog at step 5
    wait_for("step5", 5, M_ADV);
    sync_y = 0;
    repeat (21) @(negedge clk);
    check("pre_fault", int'(fault), 0);
    @(negedge clk);
    check("fault_set",      int'(fault),    1);
    check("fault_run",      int'(run),      0);
    check("fault_busy",     int'(busy),     0);
    check("fault_selector", int'(selector), 5);
    repeat (4) @(negedge clk);
    check("fault_ignores_start", int'(fault), 1);
    start = 0; clear_fault = 1;
    @(negedge clk);
    check("clear_fault",    int'(fault),    0);
    check("clear_busy",     int'(busy),     0);
    check("clear_selector", int'(selector), 5);
    clear_fault = 0; start = 1; sync_y = 1;
    @(negedge clk);
    check("resume_selector", int'(selector), 5);
    check("resume_run",      int'(run),      1);

    // Y rising on the last permitted WAIT cycle wins over the timeout
    wait_for("step6", 6, M_ADV);
    sync_y = 0;
    repeat (21) @(negedge clk);
    sync_y = 1;
    @(negedge clk);
    check("edge_no_fault", int'(fault), 0);
    check("edge_run",      int'(run),   1);
    check("edge_busy",     int'(busy),  1);

    // stop during dwell at step 9
    wait_for("dwell9", 9, M_DWELL);
    stop = 1; start = 0;
    @(negedge clk);
    check("stop_selector", int'(selector), 9);
    check("stop_run",      int'(run),      0);
    check("stop_busy",     int'(busy),     0);
    stop = 0; start = 1;
    @(negedge clk);
    check("restart_selector", int'(selector), 9);
    check("restart_run",      int'(run),      1);
    check("restart_dir",      int'(dir),      1);

    reset = 1;
    @(negedge clk);
    check("rst2_selector", int'(selector), 0);
    check("rst2_run",      int'(run),      0);
    check("rst2_busy",     int'(busy),     0);
    check("rst2_dir",      int'(dir),      0);
    check("rst2_sync_en",  int'(sync_en),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
